// File: rtl/secure_rx_if.sv
// secure_rx_if: encrypted byte input, plaintext output and status bundle of secure_rx_deframer
interface secure_rx_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        frame_ok;
    logic        frame_bad;
    logic        frame_ovf;
    logic [15:0] ok_count;
    logic [15:0] err_count;
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last,
        input  frame_ok, frame_bad, frame_ovf, ok_count, err_count
    );
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last,
        output frame_ok, frame_bad, frame_ovf, ok_count, err_count
    );
endinterface

// File: rtl/secure_rx_deframer.sv
// secure_rx_deframer: decrypts and buffers a tagged frame, releasing it only on tag match.
// Define SECURE_RX_STATS_EN to build the ok/err frame counters.
module decrypt (
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);
    assign o_data = {i_data[3:0], i_data[7:4]} ^ 8'h5A;
endmodule

module hash (
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);
    assign o_data = {i_data[6:0], i_data[7]} ^ 8'hC3;
endmodule

module secure_rx_deframer #(
    parameter int DEPTH = 16
) (
    input logic        clk,
    input logic        rst,
    secure_rx_if.slave s_if
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {RECV, DISCARD, OVF, CHECK, DRAIN} state_t;

    state_t      r_state, w_next;
    logic [AW:0] r_cnt;
    logic [AW-1:0] r_rd;
    logic [7:0]  r_acc;
    logic        r_match;
    logic [7:0]  r_buf [DEPTH];
    logic [7:0]  w_dec, w_hash;
    logic        w_in_ready, w_out_valid, w_in_fire, w_out_fire;
    logic        w_last, w_full, w_wr, w_clr, w_check;

    decrypt u_dec (.i_data(s_if.in_data), .o_data(w_dec));
    hash    u_hash (.i_data(s_if.in_data), .o_data(w_hash));

    assign w_in_ready  = (r_state == RECV) || (r_state == DISCARD);
    assign w_out_valid = r_state == DRAIN;
    assign w_check     = r_state == CHECK;
    assign w_in_fire   = s_if.in_valid && w_in_ready;
    assign w_out_fire  = w_out_valid && s_if.out_ready;
    assign w_last      = {1'b0, r_rd} == r_cnt - 1'b1;
    assign w_full      = r_cnt == FULL;
    assign w_wr        = (r_state == RECV) && w_in_fire && !s_if.in_last && !w_full;
    // every path back to RECV except a plain data byte wipes the frame context
    assign w_clr       = (r_state == OVF) || (w_check && !(r_match && r_cnt != '0)) ||
                         (w_out_fire && w_last);

    assign s_if.in_ready  = w_in_ready;
    assign s_if.out_valid = w_out_valid;
    assign s_if.out_data  = w_out_valid ? r_buf[r_rd] : 8'h00;
    assign s_if.out_last  = w_out_valid && w_last;
    assign s_if.frame_ok  = w_check && r_match;
    assign s_if.frame_bad = w_check && !r_match;
    assign s_if.frame_ovf = r_state == OVF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RECV;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RECV:    if (w_in_fire) w_next = s_if.in_last ? CHECK : (w_full ? DISCARD : RECV);
            DISCARD: if (w_in_fire && s_if.in_last) w_next = OVF;
            OVF:     w_next = RECV;
            CHECK:   w_next = (r_match && r_cnt != '0) ? DRAIN : RECV;
            DRAIN:   if (w_out_fire && w_last) w_next = RECV;
            default: w_next = RECV;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rd    <= '0;
            r_acc   <= '0;
            r_match <= 1'b0;
        end else begin
            if (w_clr) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else if (w_wr) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= r_acc ^ w_hash;
            end
            if ((r_state == RECV) && w_in_fire && s_if.in_last) r_match <= r_acc == s_if.in_data;
            if (w_out_fire) r_rd <= w_last ? '0 : r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_buf[r_cnt[AW-1:0]] <= w_dec;
    end

`ifdef SECURE_RX_STATS_EN
    logic [15:0] r_ok_cnt, r_err_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ok_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            if (s_if.frame_ok) r_ok_cnt <= r_ok_cnt + 1'b1;
            if (s_if.frame_bad || s_if.frame_ovf) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end
    assign s_if.ok_count  = r_ok_cnt;
    assign s_if.err_count = r_err_cnt;
`else
    assign s_if.ok_count  = 16'h0000;
    assign s_if.err_count = 16'h0000;
`endif
endmodule
